// File: rtl/alarm.sv
// -----------------------------------------------------------------------------
// alarm: countdown alarm timer with an MM:SS display (00:00 to 99:59).
//
// The minute and second buttons set the time while idle. The start button
// starts the countdown, and pressing it again pauses the countdown. When the
// time reaches 00:00 the buzzer sounds. Any button press then silences it.
//
// Ports
//   c              system clock, rising edge
//   rst_n          asynchronous active-low reset
//   mb / sb        minute / second buttons (asynchronous, active-high)
//   start          start / pause button (asynchronous, active-high)
//   l1..l4         BCD digits: minutes tens, minutes ones, seconds tens,
//                  seconds ones
//   L1..L4         active-high 7-segment patterns for l1..l4, bit order
//                  {g,f,e,d,c,b,a}
//   buzz           alarm buzzer, active-high
//   clk            square wave at the tick rate (high for the first half of
//                  each prescaler period)
//
// Parameters
//   DIV            system clock cycles per countdown tick (even, >= 2)
//   BUZZ_TICKS     ticks the buzzer stays on before it clears itself
//
// Build option
//   BUZZ_TIMEOUT_EN  When defined, the prescaler keeps running in ALARM. The
//                    buzzer then clears by itself after BUZZ_TICKS ticks.
//                    When undefined, the buzzer stays on until a button edge
//                    or reset.
// -----------------------------------------------------------------------------
module alarm #(
    parameter int DIV        = 100000000,
    parameter int BUZZ_TICKS = 30
) (
    input  logic       c,
    input  logic       rst_n,
    input  logic       mb,
    input  logic       sb,
    input  logic       start,
    output logic [3:0] l1,
    output logic [3:0] l2,
    output logic [3:0] l3,
    output logic [3:0] l4,
    output logic [6:0] L1,
    output logic [6:0] L2,
    output logic [6:0] L3,
    output logic [6:0] L4,
    output logic       buzz,
    output logic       clk
);

    localparam int            PW         = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(DIV / 2);
    localparam int            TW         = $clog2(BUZZ_TICKS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    state_t        state_q, state_d;

    logic [2:0]    btn_raw_s, btn_s1_q, btn_s2_q, btn_p_q, btn_rise_s;
    logic          mb_rise_s, sb_rise_s, st_rise_s, any_rise_s;

    logic [3:0]    l1_q, l2_q, l3_q, l4_q;
    logic [3:0]    l1_d, l2_d, l3_d, l4_d;
    logic [3:0]    adj1_s, adj2_s, adj3_s, adj4_s;
    logic [3:0]    dec1_s, dec2_s, dec3_s, dec4_s;
    logic          borrow4_s, borrow3_s;
    logic          adj_zero_s, last_sec_s;

    logic [PW-1:0] presc_q, presc_d;
    logic          presc_run_s, tick_s, timeout_s;
    logic          buzz_q, buzz_d, clk_q, clk_d;

`ifdef BUZZ_TIMEOUT_EN
    logic [TW-1:0] tcnt_q, tcnt_d;
`else
    // BUZZ_TICKS has no effect in this build. It is tied off here so that the
    // parameter stays referenced.
    logic [TW-1:0] unused_ticks_s;
    assign unused_ticks_s = TW'(BUZZ_TICKS);
`endif

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign btn_raw_s = {start, sb, mb};

    // Two-flop synchronizers, plus a delayed copy used for rising-edge detection
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= 3'b000;
            btn_s2_q <= 3'b000;
            btn_p_q  <= 3'b000;
        end else begin
            btn_s1_q <= btn_raw_s;
            btn_s2_q <= btn_s1_q;
            btn_p_q  <= btn_s2_q;
        end
    end

    // Button edges, setting-mode adjustments, BCD decrement and prescaler tick
    always_comb begin
        btn_rise_s = btn_s2_q & ~btn_p_q;
        mb_rise_s  = btn_rise_s[0];
        sb_rise_s  = btn_rise_s[1];
        st_rise_s  = btn_rise_s[2];
        any_rise_s = |btn_rise_s;

        // Minutes wrap 99 -> 00 and seconds wrap 59 -> 00; neither carries.
        adj2_s = mb_rise_s ? ((l2_q == 4'd9) ? 4'd0 : l2_q + 4'd1) : l2_q;
        adj1_s = (mb_rise_s && (l2_q == 4'd9)) ?
                 ((l1_q == 4'd9) ? 4'd0 : l1_q + 4'd1) : l1_q;
        adj4_s = sb_rise_s ? ((l4_q == 4'd9) ? 4'd0 : l4_q + 4'd1) : l4_q;
        adj3_s = (sb_rise_s && (l4_q == 4'd9)) ?
                 ((l3_q == 4'd5) ? 4'd0 : l3_q + 4'd1) : l3_q;
        adj_zero_s = (adj1_s == 4'd0) && (adj2_s == 4'd0) &&
                     (adj3_s == 4'd0) && (adj4_s == 4'd0);

        // One-second BCD decrement. The countdown never decrements from
        // 00:00, so minutes tens needs no underflow handling.
        borrow4_s = (l4_q == 4'd0);
        borrow3_s = borrow4_s && (l3_q == 4'd0);
        dec4_s    = borrow4_s ? 4'd9 : l4_q - 4'd1;
        dec3_s    = borrow4_s ? ((l3_q == 4'd0) ? 4'd5 : l3_q - 4'd1) : l3_q;
        dec2_s    = borrow3_s ? ((l2_q == 4'd0) ? 4'd9 : l2_q - 4'd1) : l2_q;
        dec1_s    = (borrow3_s && (l2_q == 4'd0)) ? l1_q - 4'd1 : l1_q;
        last_sec_s = (l1_q == 4'd0) && (l2_q == 4'd0) &&
                     (l3_q == 4'd0) && (l4_q == 4'd1);

`ifdef BUZZ_TIMEOUT_EN
        presc_run_s = (state_q == ST_RUN) || (state_q == ST_ALARM);
`else
        presc_run_s = (state_q == ST_RUN);
`endif
        tick_s = presc_run_s && (presc_q == PRESC_LAST);

`ifdef BUZZ_TIMEOUT_EN
        timeout_s = tick_s && (state_q == ST_ALARM) &&
                    (tcnt_q == TW'(BUZZ_TICKS - 1));
`else
        timeout_s = 1'b0;
`endif
    end

    // FSM state register
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the start decision in IDLE uses the already-adjusted time
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (st_rise_s && !adj_zero_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (st_rise_s) begin
                    state_d = ST_IDLE;
                end else if (tick_s && last_sec_s) begin
                    state_d = ST_ALARM;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (any_rise_s || timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ALARM;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: digits, prescaler and buzzer tick counter
    always_comb begin
        l1_d    = l1_q;
        l2_d    = l2_q;
        l3_d    = l3_q;
        l4_d    = l4_q;
        presc_d = {PW{1'b0}};

        // The prescaler restarts from zero on every state change, so RUN
        // always begins a full period before its first tick.
        if (presc_run_s && (state_d == state_q)) begin
            presc_d = (presc_q == PRESC_LAST) ? {PW{1'b0}} : presc_q + PW'(1);
        end else begin
            presc_d = {PW{1'b0}};
        end

        case (state_q)
            ST_IDLE: begin
                l1_d = adj1_s;
                l2_d = adj2_s;
                l3_d = adj3_s;
                l4_d = adj4_s;
            end
            ST_RUN: begin
                // A pause requested on a tick cycle wins, and the tick is dropped.
                if (tick_s && !st_rise_s) begin
                    l1_d = dec1_s;
                    l2_d = dec2_s;
                    l3_d = dec3_s;
                    l4_d = dec4_s;
                end else begin
                    l1_d = l1_q;
                    l2_d = l2_q;
                    l3_d = l3_q;
                    l4_d = l4_q;
                end
            end
            default: begin
                l1_d = l1_q;
                l2_d = l2_q;
                l3_d = l3_q;
                l4_d = l4_q;
            end
        endcase

`ifdef BUZZ_TIMEOUT_EN
        tcnt_d = {TW{1'b0}};
        if ((state_q == ST_ALARM) && (state_d == ST_ALARM)) begin
            tcnt_d = tick_s ? tcnt_q + TW'(1) : tcnt_q;
        end else begin
            tcnt_d = {TW{1'b0}};
        end
`endif
    end

    // Datapath registers
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            l1_q    <= 4'd0;
            l2_q    <= 4'd0;
            l3_q    <= 4'd0;
            l4_q    <= 4'd0;
            presc_q <= {PW{1'b0}};
`ifdef BUZZ_TIMEOUT_EN
            tcnt_q  <= {TW{1'b0}};
`endif
        end else begin
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            l3_q    <= l3_d;
            l4_q    <= l4_d;
            presc_q <= presc_d;
`ifdef BUZZ_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
`endif
        end
    end

    // FSM outputs: buzzer and tick clock next values, and segment decode
    always_comb begin
        buzz_d = (state_d == ST_ALARM);
        clk_d  = (presc_d < PRESC_HALF);
        L1     = seg7(l1_q);
        L2     = seg7(l2_q);
        L3     = seg7(l3_q);
        L4     = seg7(l4_q);
    end

    // Registered buzzer and tick clock
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            buzz_q <= 1'b0;
            clk_q  <= 1'b1;
        end else begin
            buzz_q <= buzz_d;
            clk_q  <= clk_d;
        end
    end

    assign l1   = l1_q;
    assign l2   = l2_q;
    assign l3   = l3_q;
    assign l4   = l4_q;
    assign buzz = buzz_q;
    assign clk  = clk_q;

endmodule

// File: tb/tb_alarm.sv
module tb_alarm;

    localparam int DIV = 4;
    localparam int BT  = 3;

    logic       c     = 1'b0;
    logic       rst_n = 1'b0;
    logic       mb    = 1'b0;
    logic       sb    = 1'b0;
    logic       start = 1'b0;
    logic [3:0] l1, l2, l3, l4;
    logic [6:0] L1, L2, L3, L4;
    logic       buzz, clk_w;

    alarm #(.DIV(DIV), .BUZZ_TICKS(BT)) dut (
        .c(c), .rst_n(rst_n), .mb(mb), .sb(sb), .start(start),
        .l1(l1), .l2(l2), .l3(l3), .l4(l4),
        .L1(L1), .L2(L2), .L3(L3), .L4(L4),
        .buzz(buzz), .clk(clk_w)
    );

    always #5 c = ~c;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: whole minutes/seconds, a mode and a cycle phase counter
    int mm_m, ss_m, mode_m, phase_m, tcnt_m;   // mode: 0 idle, 1 run, 2 alarm
    bit hm[3], hs[3], ht[3];                   // input samples at n-1, n-2, n-3
    logic [6:0]  seg_tab[10];
    logic [45:0] rst_vec;

    typedef struct {
        logic m;
        logic s;
        logic st;
        int   hold;
        int   emm;
        int   ess;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mm_m = 0; ss_m = 0; mode_m = 0; phase_m = 0; tcnt_m = 0;
        for (int i = 0; i < 3; i++) begin
            hm[i] = 1'b0; hs[i] = 1'b0; ht[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit em, es, et;
        int t;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // A press acts at the edge where the input was seen high two edges ago
        // and low three edges ago.
        em = hm[1] && !hm[2];
        es = hs[1] && !hs[2];
        et = ht[1] && !ht[2];
        hm[2] = hm[1]; hm[1] = hm[0]; hm[0] = mb;
        hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = sb;
        ht[2] = ht[1]; ht[1] = ht[0]; ht[0] = start;
        case (mode_m)
            0: begin
                if (em) mm_m = (mm_m + 1) % 100;
                if (es) ss_m = (ss_m + 1) % 60;
                if (et && (mm_m + ss_m) != 0) begin
                    mode_m = 1; phase_m = 0;
                end
            end
            1: begin
                if (et) begin
                    mode_m = 0; phase_m = 0;
                end else begin
                    phase_m++;
                    if (phase_m == DIV) begin
                        phase_m = 0;
                        t = mm_m * 60 + ss_m - 1;
                        mm_m = t / 60;
                        ss_m = t % 60;
                        tcnt_m = 0;
                        if (t == 0) mode_m = 2;
                    end
                end
            end
            default: begin
                if (em || es || et) begin
                    mode_m = 0; phase_m = 0;
                end else begin
`ifdef BUZZ_TIMEOUT_EN
                    phase_m++;
                    if (phase_m == DIV) begin
                        phase_m = 0;
                        tcnt_m++;
                        if (tcnt_m == BT) mode_m = 0;
                    end
`endif
                end
            end
        endcase
    endtask

    function automatic logic [15:0] bcd(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [45:0] model_vec();
        return {bcd(mm_m, ss_m),
                seg_tab[mm_m / 10], seg_tab[mm_m % 10],
                seg_tab[ss_m / 10], seg_tab[ss_m % 10],
                1'(mode_m == 2), 1'(phase_m < DIV / 2)};
    endfunction

    function automatic logic [45:0] dut_vec();
        return {l1, l2, l3, l4, L1, L2, L3, L4, buzz, clk_w};
    endfunction

    function automatic logic [15:0] disp();
        return {l1, l2, l3, l4};
    endfunction

    task automatic cycle();
        @(posedge c);
        model_step();
        @(negedge c);
        chk("cycle", 64'(dut_vec()), 64'(model_vec()));
    endtask

    task automatic press(input logic m, input logic s, input logic st, input int hold);
        mb = m; sb = s; start = st;
        repeat (hold) cycle();
        mb = 1'b0; sb = 1'b0; start = 1'b0;
        repeat (4) cycle();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_clk[9] = '{1, 1, 0, 0, 1, 1, 0, 0, 1};
        int exp_sec[9] = '{2, 2, 2, 2, 1, 1, 1, 1, 0};
        int exp_bz[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        int n, hold;

        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        rst_vec = {16'h0000, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b0, 1'b1};
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1,  0, 1};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1,  0, 2};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1,  0, 3};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1,  1, 3};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 20, 1, 4};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1,  2, 5};
        model_reset();

        // Reset, then release; a start press at 00:00 is ignored
        repeat (3) cycle();
        chk("reset", 64'(dut_vec()), 64'(rst_vec));
        rst_n = 1'b1;
        while ($time < 500) cycle();
        start = 1'b1;
        repeat (60) cycle();
        start = 1'b0;
        repeat (4) cycle();
        chk("start_at_zero", 64'({disp(), buzz, clk_w}), 64'({16'h0000, 1'b0, 1'b1}));

        // Table of setting presses
        for (int i = 0; i < 6; i++) begin
            press(tbl[i].m, tbl[i].s, tbl[i].st, tbl[i].hold);
            chk($sformatf("vec%0d", i), 64'(disp()), 64'(bcd(tbl[i].emm, tbl[i].ess)));
            if (i == 3) begin
                chk("seg_L4_3", 64'(L4), 64'(7'h4F));
                chk("seg_L2_1", 64'(L2), 64'(7'h06));
            end
        end

        // Seconds wrap without carry, minutes wrap 99 -> 00
        repeat (54) press(1'b0, 1'b1, 1'b0, 1);
        chk("sec_59", 64'(disp()), 64'(bcd(2, 59)));
        press(1'b0, 1'b1, 1'b0, 1);
        chk("sec_wrap", 64'(disp()), 64'(bcd(2, 0)));
        repeat (97) press(1'b1, 1'b0, 1'b0, 1);
        chk("min_99", 64'(disp()), 64'(bcd(99, 0)));
        press(1'b1, 1'b0, 1'b0, 1);
        chk("min_wrap", 64'(disp()), 64'(bcd(0, 0)));

        // 00:02 countdown, cycle by cycle from RUN entry
        press(1'b0, 1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 1'b0, 1);
        start = 1'b1;
        repeat (3) cycle();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) cycle();
            chk($sformatf("run_clk%0d", k), 64'(clk_w), 64'(exp_clk[k]));
            chk($sformatf("run_sec%0d", k), 64'(disp()), 64'(bcd(0, exp_sec[k])));
            chk($sformatf("run_buzz%0d", k), 64'(buzz), 64'(exp_bz[k]));
        end
        press(1'b1, 1'b0, 1'b0, 1);
        chk("alarm_mb_clear", 64'({disp(), buzz}), 64'({16'h0000, 1'b0}));

        // Buzzer persistence (or auto-clear when the timeout is built in)
        press(1'b0, 1'b1, 1'b0, 1);
        start = 1'b1;
        repeat (3) cycle();
        start = 1'b0;
        n = 0;
        while (!buzz && n < 50) begin
            cycle();
            n++;
        end
        chk("first_tick_latency", 64'(n), 64'(DIV));
        hold = 0;
        while (buzz && hold < 40) begin
            cycle();
            hold++;
        end
`ifdef BUZZ_TIMEOUT_EN
        chk("buzz_timeout", 64'(hold), 64'(BT * DIV));
`else
        chk("buzz_persist", 64'({buzz, disp()}), 64'({1'b1, 16'h0000}));
`endif
        press(1'b0, 1'b0, 1'b1, 1);
        chk("alarm_start_clear", 64'({disp(), buzz}), 64'({16'h0000, 1'b0}));

        // Start together with mb at 00:00 runs on the adjusted time
        press(1'b1, 1'b0, 1'b1, 1);
        chk("start_adj_run", 64'({disp(), clk_w}), 64'({bcd(1, 0), 1'b0}));

        // Asynchronous reset in the middle of RUN
        repeat (3) cycle();
        #2 rst_n = 1'b0;
        #1 chk("reset_midrun", 64'(dut_vec()), 64'(rst_vec));
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;

        // Borrow 01:00 -> 00:59, then pause and resume setting
        press(1'b1, 1'b0, 1'b0, 1);
        start = 1'b1;
        repeat (3) cycle();
        start = 1'b0;
        repeat (2) cycle();
        start = 1'b1;
        repeat (2) cycle();
        chk("borrow", 64'(disp()), 64'(bcd(0, 59)));
        cycle();
        start = 1'b0;
        repeat (20) cycle();
        chk("pause_hold", 64'({disp(), clk_w}), 64'({bcd(0, 59), 1'b1}));
        press(1'b1, 1'b0, 1'b0, 1);
        chk("pause_mb", 64'(disp()), 64'(bcd(1, 59)));

        // Random button activity against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) mb = ~mb;
            if ($urandom_range(0, 5) == 0) sb = ~sb;
            if ($urandom_range(0, 39) == 0) start = ~start;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm.md
Name: alarm

Overview:
- Countdown alarm timer with an MM:SS display (00:00–99:59), set by minute/second push-buttons and started by a start button.
- Drives four 7-segment digits plus their BCD values, a buzzer output, and a divided "seconds" clock for the board.
- Sits at the top of the board design, directly between the buttons/system clock and the display/buzzer pins.

Parameters:
- DIV, 100000000, system-clock cycles per countdown tick (1 s at 100 MHz); must be even and >=2; benches use 4.
- BUZZ_TICKS, 30, ticks the buzzer stays on before auto-clear (used only with BUZZ_TIMEOUT_EN).

Ports:
- c  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mb  input  1  minute button, async, active-high.
- sb  input  1  second button, async, active-high.
- start  input  1  start/pause button, async, active-high.
- l1  output  4  BCD minutes tens.
- l2  output  4  BCD minutes ones.
- l3  output  4  BCD seconds tens.
- l4  output  4  BCD seconds ones.
- L1,L2,L3,L4  output  7 each  active-high segments for l1..l4, bit order {g,f,e,d,c,b,a}.
- buzz  output  1  alarm buzzer, active-high.
- clk  output  1  tick-rate square wave.

Behaviour:
- Reset (async, rst_n=0):
  - l1..l4=0, so L1..L4=7'h3F.
  - buzz=0, clk=1, state=IDLE, prescaler=0, synchronizers cleared.
- Inputs:
  - mb, sb, start each pass through a 2-flop synchronizer, then a rising-edge detector.
  - An action takes effect on the 3rd rising edge of c after the input rises.
  - Holding a button produces exactly one action.
- Segment decode is combinational from l*: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; values 10–15=00.
- Prescaler:
  - Counts 0..DIV-1, wrapping, and runs only in RUN.
  - clk=1 while prescaler<DIV/2, else 0.
  - A tick fires when prescaler==DIV-1.
  - Prescaler is cleared to 0 on entering RUN, so the first decrement occurs DIV cycles after entry.
- IDLE (setting):
  - mb edge: minutes+1, 99 wraps to 00, seconds unchanged.
  - sb edge: seconds+1, 59 wraps to 00, no carry into minutes.
  - start edge with time!=00:00: go to RUN. With time==00:00: ignored.
  - Simultaneous mb and sb edges: both apply. Start edge in the same cycle as mb/sb: the adjust applies first, then the RUN decision uses the adjusted time.
- RUN:
  - Each tick decrements MM:SS by one second in BCD; xx:00 borrows to (xx-1):59.
  - mb and sb are ignored.
  - start edge pauses: go to IDLE, time retained, prescaler cleared.
  - A tick that takes 00:01 to 00:00 moves to ALARM and sets buzz=1 in the same cycle the display shows 00:00.
- ALARM:
  - buzz=1 and time holds 00:00.
  - Any mb/sb/start edge: buzz=0, go to IDLE. That edge is consumed and does not increment.
- Asserting reset in any state immediately forces the reset values above.

Optional Feature:
- Macro BUZZ_TIMEOUT_EN.
- Defined: in ALARM the prescaler keeps running and ticks are counted. After BUZZ_TICKS ticks, buzz clears and the state returns to IDLE automatically; a button edge still clears it earlier.
- Undefined: buzz stays asserted until a button edge or reset, and the prescaler is idle in ALARM.

Test Plan:
- Reset, then release with no buttons pressed -> l1..l4=0, L1..L4=7'h3F, buzz=0, clk=1 steady; a start pulse at 500 ns held 600 ns is ignored (time 00:00).
- DIV=4; pulse sb 3x and mb 1x -> display 01:03, L4=7'h4F, L2=7'h06; hold sb 20 cycles -> exactly one increment (01:04).
- Count sb edges from 00:59 -> 00:00 (no carry). Count mb edges from 99 -> 00.
- DIV=4, set 00:02, pulse start:
  - clk toggles every 2 cycles.
  - Display 00:01 after 4 cycles and 00:00 after 8.
  - buzz=1 in the same cycle as 00:00.
- Set 01:00, run 1 tick -> 00:59 (borrow). Pulse start -> pause; count holds for 20 cycles. Pulse mb -> 01:59.
- In ALARM pulse mb -> buzz=0, time 00:00, state IDLE. With BUZZ_TIMEOUT_EN, BUZZ_TICKS=3, DIV=4: buzz clears 12 cycles after asserting. Assert rst_n=0 mid-RUN -> all outputs at reset values immediately.
